// File: rtl/nav_pkg.sv
// nav_pkg
// Shared constants and types for the navigation sequencer:
//   - one-hot combat modes driven to the velocity block
//   - one-hot position-control modes driven to the position block
//   - sequencer state encoding
//   - legality check for incoming mode commands
package nav_pkg;

  localparam logic [3:0] MODE_RESET   = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam logic [3:0] POS_RESET  = 4'b0001;
  localparam logic [3:0] POS_NORMAL = 4'b0010;
  localparam logic [3:0] POS_JUMP   = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CRUISE   = 3'd1,
    ST_SPOOL    = 3'd2,
    ST_JUMP     = 3'd3,
    ST_COOLDOWN = 3'd4
  } nav_state_t;

  // Only the three combat modes may be commanded; MODE_RESET, zero and
  // multi-hot patterns are rejected.
  function automatic logic is_legal_mode(input logic [3:0] m);
    return (m == MODE_ATTACK) || (m == MODE_DEFENSE) || (m == MODE_STEALTH);
  endfunction

endpackage

// File: rtl/nav_sequencer_if.sv
// nav_sequencer_if
// Pilot-side control bundle of the navigation sequencer.
//   master : pilot logic (drives launch/halt/cmd/jump requests, reads outputs)
//   slave  : nav_sequencer (reads requests, drives modes, target and pulses)
// jump_target / jump_position are packed {Z,Y,X}, K bits per axis.
interface nav_sequencer_if #(
  parameter int K = 16
) ();

  logic             launch;
  logic             halt;
  logic             cmd_valid;
  logic [3:0]       cmd_mode;
  logic             jump_req;
  logic [3*K-1:0]   jump_target;
  logic             abort;

  logic [3:0]       mode;
  logic [3:0]       pos_mode;
  logic [3*K-1:0]   jump_position;
  logic             jump_ack;
  logic             jump_err;
  logic             jump_done;
  logic             busy;

  modport master (
    output launch, halt, cmd_valid, cmd_mode, jump_req, jump_target, abort,
    input  mode, pos_mode, jump_position, jump_ack, jump_err, jump_done, busy
  );

  modport slave (
    input  launch, halt, cmd_valid, cmd_mode, jump_req, jump_target, abort,
    output mode, pos_mode, jump_position, jump_ack, jump_err, jump_done, busy
  );

endinterface

// File: rtl/nav_countdown.sv
// nav_countdown
// Down-counter used to time the SPOOL and COOLDOWN phases.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : force count to zero (highest priority after reset)
//   load        : load load_value
//   dec         : decrement, only while count > 1 so the counter never wraps
//   expire      : count == 1, i.e. this is the last cycle of the phase
module nav_countdown #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          expire
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg > CW'(1))) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign expire = (count_reg == CW'(1));

endmodule

// File: rtl/nav_sequencer.sv
// nav_sequencer
// Owns the control inputs of the position/velocity datapath. Issues the
// one-hot combat mode and position mode every cycle, accepts jump requests
// over a req/ack handshake and runs each jump through SPOOL -> JUMP ->
// COOLDOWN.
//   clk    : clock, all state updates on posedge
//   reset  : synchronous, active-high
//   bus    : nav_sequencer_if.slave (launch/halt/cmd/jump inputs,
//            mode/pos_mode/jump_position/pulses/busy outputs)
// Every output is a register; output values are computed from the next
// state so they line up with the state they describe.
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int k               = 16,
  parameter int SPOOL_CYCLES    = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CW              = 8
) (
  input  logic            clk,
  input  logic            reset,
  nav_sequencer_if.slave  bus
);

  localparam logic [CW-1:0] SPOOL_LOAD    = CW'(SPOOL_CYCLES);
  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(COOLDOWN_CYCLES);

  nav_state_t    state_reg, state_next;
  logic [3:0]    cur_mode_reg, cur_mode_next;
  logic [3:0]    mode_reg, mode_next;
  logic [3:0]    pos_mode_reg, pos_mode_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;

  logic          cnt_clear;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_value;
  logic          cnt_dec;
  logic          cnt_expire;
  logic          latch_target;

  nav_countdown #(
    .CW(CW)
  ) u_countdown (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .expire     (cnt_expire)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cur_mode_reg <= MODE_ATTACK;
      mode_reg     <= MODE_RESET;
      pos_mode_reg <= POS_RESET;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_mode_reg <= cur_mode_next;
      mode_reg     <= mode_next;
      pos_mode_reg <= pos_mode_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic. Event priority inside each state follows
  // halt > abort > counter expiry > jump_req.
  always_comb begin
    state_next     = state_reg;
    cur_mode_next  = cur_mode_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    done_next      = 1'b0;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    latch_target   = 1'b0;

    // Mode commands apply alongside any other event, except while parked.
    if ((state_reg != ST_IDLE) && bus.cmd_valid && is_legal_mode(bus.cmd_mode)) begin
      cur_mode_next = bus.cmd_mode;
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.launch) begin
          state_next = ST_CRUISE;
        end
      end

      ST_CRUISE: begin
        if (bus.halt) begin
          state_next = ST_IDLE;
          cnt_clear  = 1'b1;
        end else if (bus.jump_req) begin
          // Acceptance is judged on the mode in force, not one arriving now.
          if (cur_mode_reg == MODE_STEALTH) begin
            err_next = 1'b1;
          end else begin
            latch_target   = 1'b1;
            cnt_load       = 1'b1;
            cnt_load_value = SPOOL_LOAD;
            ack_next       = 1'b1;
            state_next     = ST_SPOOL;
          end
        end
      end

      ST_SPOOL: begin
        if (bus.halt) begin
          state_next = ST_IDLE;
          cnt_clear  = 1'b1;
        end else if (bus.abort) begin
          state_next = ST_CRUISE;
          cnt_clear  = 1'b1;
        end else if (cnt_expire) begin
          state_next = ST_JUMP;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_JUMP: begin
        // The jump always lands; a halt here only replaces COOLDOWN by IDLE.
        done_next = 1'b1;
        if (bus.halt) begin
          state_next = ST_IDLE;
          cnt_clear  = 1'b1;
        end else begin
          cnt_load       = 1'b1;
          cnt_load_value = COOLDOWN_LOAD;
          state_next     = ST_COOLDOWN;
        end
      end

      ST_COOLDOWN: begin
        // jump_req is deliberately not looked at here; it waits for CRUISE.
        if (bus.halt) begin
          state_next = ST_IDLE;
          cnt_clear  = 1'b1;
        end else if (cnt_expire) begin
          state_next = ST_CRUISE;
          cnt_clear  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Output decode from the state being entered, so mode/pos_mode/busy are
  // registered in the same edge as the state itself.
  always_comb begin
    mode_next     = MODE_RESET;
    pos_mode_next = POS_RESET;
    busy_next     = 1'b0;
    case (state_next)
      ST_IDLE: begin
        mode_next     = MODE_RESET;
        pos_mode_next = POS_RESET;
      end
      ST_CRUISE: begin
        mode_next     = cur_mode_next;
        pos_mode_next = POS_NORMAL;
      end
      ST_SPOOL: begin
        mode_next     = MODE_DEFENSE;
        pos_mode_next = POS_NORMAL;
        busy_next     = 1'b1;
      end
      ST_JUMP: begin
        mode_next     = MODE_DEFENSE;
        pos_mode_next = POS_JUMP;
        busy_next     = 1'b1;
      end
      ST_COOLDOWN: begin
        mode_next     = cur_mode_next;
        pos_mode_next = POS_NORMAL;
        busy_next     = 1'b1;
      end
      default: begin
        mode_next     = MODE_RESET;
        pos_mode_next = POS_RESET;
      end
    endcase
  end

  // Per-axis target latch; the position only changes when a request is
  // accepted and otherwise holds across jumps.
  logic [2:0][k-1:0] axis_position;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic [k-1:0] axis_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          axis_reg <= '0;
        end else if (latch_target) begin
          axis_reg <= bus.jump_target[gi*k +: k];
        end
      end

      assign axis_position[gi] = axis_reg;
    end
  endgenerate

  assign bus.jump_position = axis_position;
  assign bus.mode          = mode_reg;
  assign bus.pos_mode      = pos_mode_reg;
  assign bus.jump_ack      = ack_reg;
  assign bus.jump_err      = err_reg;
  assign bus.jump_done     = done_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_nav_sequencer.sv
// tb_nav_sequencer
// Directed bench for nav_sequencer (SPOOL_CYCLES=4, COOLDOWN_CYCLES=8).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. they show the result of the edge just taken.
module tb_nav_sequencer;

  localparam int K = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  nav_sequencer_if #(.K(K)) bus ();

  nav_sequencer #(
    .k               (K),
    .SPOOL_CYCLES    (4),
    .COOLDOWN_CYCLES (8),
    .CW              (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] observed,
                          input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end else begin
      $display("ok   %s: %h", tag, observed);
    end
  endtask

  // Packs {mode, pos_mode, ack, err, done, busy} into one comparison.
  task automatic expect_outs(input string tag, input logic [3:0] m,
                             input logic [3:0] p, input logic a, input logic e,
                             input logic d, input logic b);
    check_eq(tag,
             {52'd0, bus.mode, bus.pos_mode, bus.jump_ack, bus.jump_err,
              bus.jump_done, bus.busy},
             {52'd0, m, p, a, e, d, b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3*K-1:0] tgt_a, tgt_b, tgt_c;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tgt_a = {16'd100, 16'd100, 16'd100};
    tgt_b = {16'd3, 16'd2, 16'd1};
    tgt_c = {16'd9, 16'd8, 16'd7};

    reset           = 1'b1;
    bus.launch      = 1'b0;
    bus.halt        = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_mode    = 4'b0000;
    bus.jump_req    = 1'b0;
    bus.jump_target = '0;
    bus.abort       = 1'b0;

    // Reset values
    tick();
    tick();
    expect_outs("reset_outs", 4'b0001, 4'b0001, 0, 0, 0, 0);
    check_eq("reset_jpos", {16'd0, bus.jump_position}, 64'd0);

    // IDLE ignores requests and mode commands
    reset           = 1'b0;
    bus.jump_req    = 1'b1;
    bus.jump_target = tgt_a;
    bus.cmd_valid   = 1'b1;
    bus.cmd_mode    = 4'b1000;
    tick();
    expect_outs("idle_ignore", 4'b0001, 4'b0001, 0, 0, 0, 0);
    check_eq("idle_jpos", {16'd0, bus.jump_position}, 64'd0);
    bus.jump_req  = 1'b0;
    bus.cmd_valid = 1'b0;

    // Launch into CRUISE with ATTACK
    bus.launch = 1'b1;
    tick();
    bus.launch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_outs($sformatf("cruise_%0d", i), 4'b0010, 4'b0010, 0, 0, 0, 0);
      tick();
    end

    // Full jump
    bus.jump_target = tgt_a;
    bus.jump_req    = 1'b1;
    tick();
    expect_outs("spool_ack", 4'b0100, 4'b0010, 1, 0, 0, 1);
    check_eq("jpos_a", {16'd0, bus.jump_position}, {16'd0, tgt_a});
    bus.jump_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      expect_outs($sformatf("spool_%0d", i), 4'b0100, 4'b0010, 0, 0, 0, 1);
    end
    tick();
    expect_outs("jump_cycle", 4'b0100, 4'b0100, 0, 0, 0, 1);
    tick();
    expect_outs("cool_done", 4'b0010, 4'b0010, 0, 0, 1, 1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      expect_outs($sformatf("cool_%0d", i), 4'b0010, 4'b0010, 0, 0, 0, 1);
    end
    tick();
    expect_outs("back_cruise", 4'b0010, 4'b0010, 0, 0, 0, 0);

    // STEALTH rejects the request
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 4'b1000;
    tick();
    bus.cmd_valid = 1'b0;
    expect_outs("stealth_mode", 4'b1000, 4'b0010, 0, 0, 0, 0);
    bus.jump_target = tgt_b;
    bus.jump_req    = 1'b1;
    tick();
    bus.jump_req = 1'b0;
    expect_outs("stealth_err", 4'b1000, 4'b0010, 0, 1, 0, 0);
    check_eq("stealth_jpos", {16'd0, bus.jump_position}, {16'd0, tgt_a});
    tick();
    expect_outs("err_clear", 4'b1000, 4'b0010, 0, 0, 0, 0);

    // Illegal commands ignored
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 4'b0001;
    tick();
    expect_outs("cmd_0001", 4'b1000, 4'b0010, 0, 0, 0, 0);
    bus.cmd_mode = 4'b0110;
    tick();
    expect_outs("cmd_multihot", 4'b1000, 4'b0010, 0, 0, 0, 0);
    bus.cmd_mode = 4'b0010;
    tick();
    bus.cmd_valid = 1'b0;
    expect_outs("cmd_attack", 4'b0010, 4'b0010, 0, 0, 0, 0);

    // Abort in the second SPOOL cycle
    bus.jump_target = tgt_b;
    bus.jump_req    = 1'b1;
    tick();
    bus.jump_req = 1'b0;
    expect_outs("abort_ack", 4'b0100, 4'b0010, 1, 0, 0, 1);
    check_eq("jpos_b", {16'd0, bus.jump_position}, {16'd0, tgt_b});
    tick();
    expect_outs("abort_spool2", 4'b0100, 4'b0010, 0, 0, 0, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_outs($sformatf("after_abort_%0d", i), 4'b0010, 4'b0010, 0, 0, 0, 0);
      tick();
    end

    // halt and abort together in SPOOL -> IDLE
    bus.jump_target = tgt_c;
    bus.jump_req    = 1'b1;
    tick();
    bus.jump_req = 1'b0;
    expect_outs("ha_ack", 4'b0100, 4'b0010, 1, 0, 0, 1);
    bus.halt  = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.halt  = 1'b0;
    bus.abort = 1'b0;
    expect_outs("ha_idle", 4'b0001, 4'b0001, 0, 0, 0, 0);
    check_eq("ha_jpos_hold", {16'd0, bus.jump_position}, {16'd0, tgt_c});

    // halt on the JUMP cycle: jump lands, done pulses, then IDLE
    bus.launch = 1'b1;
    tick();
    bus.launch = 1'b0;
    bus.jump_target = tgt_a;
    bus.jump_req    = 1'b1;
    tick();
    bus.jump_req = 1'b0;
    expect_outs("hj_ack", 4'b0100, 4'b0010, 1, 0, 0, 1);
    tick();
    tick();
    tick();
    tick();
    expect_outs("hj_jump", 4'b0100, 4'b0100, 0, 0, 0, 1);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    expect_outs("hj_done_idle", 4'b0001, 4'b0001, 0, 0, 1, 0);
    tick();
    expect_outs("hj_idle", 4'b0001, 4'b0001, 0, 0, 0, 0);

    // reset during COOLDOWN, with a held request and a mode command
    bus.launch = 1'b1;
    tick();
    bus.launch = 1'b0;
    bus.jump_target = tgt_b;
    bus.jump_req    = 1'b1;
    tick();
    bus.jump_req = 1'b0;
    expect_outs("rc_ack", 4'b0100, 4'b0010, 1, 0, 0, 1);
    tick();
    tick();
    tick();
    tick();
    tick();
    expect_outs("rc_cool1", 4'b0010, 4'b0010, 0, 0, 1, 1);
    bus.jump_req  = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 4'b0100;
    tick();
    bus.cmd_valid = 1'b0;
    expect_outs("rc_held_defense", 4'b0100, 4'b0010, 0, 0, 0, 1);
    tick();
    expect_outs("rc_held_noack", 4'b0100, 4'b0010, 0, 0, 0, 1);
    reset = 1'b1;
    tick();
    expect_outs("rc_reset", 4'b0001, 4'b0001, 0, 0, 0, 0);
    check_eq("rc_reset_jpos", {16'd0, bus.jump_position}, 64'd0);
    reset        = 1'b0;
    bus.jump_req = 1'b0;
    bus.launch   = 1'b1;
    tick();
    bus.launch = 1'b0;
    expect_outs("rc_relaunch_attack", 4'b0010, 4'b0010, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
